// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S word-select tracking logic.
package i2s_pkg;

    localparam int I2S_DS_W  = 5;
    localparam int I2S_WN_W  = 4;
    localparam int I2S_LEN_W = 10;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_SEEK,
        WS_MEAS,
        WS_LOCKED
    } ws_sync_state_e;

    // Expected half-frame length in sck cycles: (bits per slot) * (slots per half-frame).
    // The largest product is 32 * 16 = 512, which fits the length width.
    function automatic logic [I2S_LEN_W-1:0] half_frame_len(
        input logic [I2S_DS_W-1:0] data_size,
        input logic [I2S_WN_W-1:0] word_num
    );
        logic [I2S_LEN_W-1:0] bits_per_slot;
        logic [I2S_LEN_W-1:0] slots_per_half;
        bits_per_slot  = I2S_LEN_W'(data_size) + 10'd1;
        slots_per_half = I2S_LEN_W'(word_num) + 10'd1;
        return bits_per_slot * slots_per_half;
    endfunction

endpackage

// File: rtl/i2s_ws_sync.sv
// Slave-side I2S word-select tracker (external sck mode).
// Follows the incoming WS, regenerates bit/slot position, checks the half-frame
// length against the configured slot geometry and reports lock/error status.
// Optional macro I2S_WS_SYNC_ERR_CNT_EN adds a saturating error counter on err_cnt_o;
// without it err_cnt_o is tied to zero.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WS_IDLE   | disabled / just enabled; counters held at zero
// WS_SEEK   | waiting for the first WS edge to use as a length reference
// WS_MEAS   | measuring half-frames, counting consecutive good lengths
// WS_LOCKED | WS period matches cfg; lock_o high
module i2s_ws_sync
    import i2s_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  sck_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [4:0]            cfg_data_size_i,
    input  logic [3:0]            cfg_word_num_i,
    input  logic                  ws_i,
    output logic                  ws_o,
    output logic [4:0]            bit_o,
    output logic [3:0]            slot_o,
    output logic                  frame_start_o,
    output logic                  lock_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    localparam logic [I2S_LEN_W-1:0] LEN_MAX = '1;

    ws_sync_state_e        state_q, state_d;
    logic                  ws_q, ws_d;
    logic [I2S_LEN_W-1:0]  len_q, len_d;
    logic [I2S_DS_W-1:0]   bit_q, bit_d;
    logic [I2S_WN_W-1:0]   slot_q, slot_d;
    logic [2:0]            good_q, good_d;
    logic                  frame_start_q, frame_start_d;
    logic                  lock_q, lock_d;
    logic                  err_q, err_d;

    logic [I2S_LEN_W-1:0]  exp_len;
    logic                  ws_edge;
    logic                  len_match;
    logic [3:0]            good_inc;
    logic                  lock_hit;

    // Length check and edge detect are shared by every state.
    always_comb begin
        exp_len   = half_frame_len(cfg_data_size_i, cfg_word_num_i);
        ws_edge   = cfg_en_i & (ws_i != ws_q);
        len_match = (len_q == exp_len);
        good_inc  = {1'b0, good_q} + 4'd1;
        lock_hit  = (good_inc == 4'(LOCK_FRAMES));
    end

    // Next-state logic: WS tracking, position counters and lock FSM.
    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        err_d         = 1'b0;
        ws_d          = ws_i;
        frame_start_d = ws_edge & ~ws_i;
        bit_d         = bit_q;
        slot_d        = slot_q;

        if (ws_edge) begin
            len_d = 10'd1;
        end else if (len_q == LEN_MAX) begin
            len_d = len_q;
        end else begin
            len_d = len_q + 10'd1;
        end

        if ((state_q == WS_IDLE) || ws_edge) begin
            bit_d  = '0;
            slot_d = '0;
        end else if (bit_q == cfg_data_size_i) begin
            bit_d  = '0;
            slot_d = (slot_q == cfg_word_num_i) ? '0 : slot_q + 4'd1;
        end else begin
            bit_d  = bit_q + 5'd1;
        end

        // Edge has priority: an overrun is only a length match without an edge.
        case (state_q)
            WS_IDLE: begin
                state_d = WS_SEEK;
            end
            WS_SEEK: begin
                if (ws_edge) begin
                    state_d = WS_MEAS;
                    good_d  = '0;
                end
            end
            WS_MEAS: begin
                if (ws_edge) begin
                    if (len_match) begin
                        good_d = good_inc[2:0];
                        if (lock_hit) begin
                            state_d = WS_LOCKED;
                        end
                    end else begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end else if (len_match) begin
                    err_d   = 1'b1;
                    state_d = WS_SEEK;
                end
            end
            WS_LOCKED: begin
                if (ws_edge) begin
                    if (!len_match) begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = WS_MEAS;
                    end
                end else if (len_match) begin
                    err_d   = 1'b1;
                    state_d = WS_SEEK;
                end
            end
            default: begin
                state_d = WS_IDLE;
            end
        endcase

        lock_d = (state_d == WS_LOCKED);

        // Disable behaves like a synchronous reset of the whole tracker.
        if (!cfg_en_i) begin
            state_d       = WS_IDLE;
            good_d        = '0;
            err_d         = 1'b0;
            ws_d          = 1'b0;
            len_d         = '0;
            bit_d         = '0;
            slot_d        = '0;
            frame_start_d = 1'b0;
            lock_d        = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= WS_IDLE;
            good_q        <= '0;
            ws_q          <= 1'b0;
            len_q         <= '0;
            bit_q         <= '0;
            slot_q        <= '0;
            frame_start_q <= 1'b0;
            lock_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            ws_q          <= ws_d;
            len_q         <= len_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
            frame_start_q <= frame_start_d;
            lock_q        <= lock_d;
            err_q         <= err_d;
        end
    end

`ifdef I2S_WS_SYNC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of error pulses, cleared by reset or disable.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (!cfg_en_i) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign ws_o          = ws_q;
    assign bit_o         = bit_q;
    assign slot_o        = slot_q;
    assign frame_start_o = frame_start_q;
    assign lock_o        = lock_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_i2s_ws_sync.sv
// Self-checking bench for i2s_ws_sync: directed WS scenarios plus randomized
// half-frame lengths, compared every cycle against a behavioural model.
module tb_i2s_ws_sync;

    localparam int LOCK_FRAMES = 2;
    localparam int ERR_CNT_W   = 8;
`ifdef I2S_WS_SYNC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 sck_i = 1'b0;
    logic                 rstn_i;
    logic                 cfg_en_i;
    logic [4:0]           cfg_data_size_i;
    logic [3:0]           cfg_word_num_i;
    logic                 ws_i;
    logic                 ws_o;
    logic [4:0]           bit_o;
    logic [3:0]           slot_o;
    logic                 frame_start_o;
    logic                 lock_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    i2s_ws_sync #(.LOCK_FRAMES(LOCK_FRAMES), .ERR_CNT_W(ERR_CNT_W)) dut (
        .sck_i           (sck_i),
        .rstn_i          (rstn_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_data_size_i (cfg_data_size_i),
        .cfg_word_num_i  (cfg_word_num_i),
        .ws_i            (ws_i),
        .ws_o            (ws_o),
        .bit_o           (bit_o),
        .slot_o          (slot_o),
        .frame_start_o   (frame_start_o),
        .lock_o          (lock_o),
        .err_o           (err_o),
        .err_cnt_o       (err_cnt_o)
    );

    always #5 sck_i = ~sck_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Behavioural model. mode: 0 idle, 1 seeking, 2 measuring, 3 locked.
    // Position is derived from the cycle count since the last WS edge.
    int m_mode, m_ws, m_k, m_half, m_good, m_fs, m_lock, m_err, m_errcnt;
    int m_bit, m_slot;

    int cyc, last_fs, fs_seen, err_seen;
    bit chk_period;
    logic ws_val;

    function automatic void model_reset();
        m_mode = 0; m_ws = 0; m_k = 0; m_half = 0; m_good = 0;
        m_fs = 0; m_lock = 0; m_err = 0; m_errcnt = 0; m_bit = 0; m_slot = 0;
    endfunction

    function automatic void model_step();
        int  ds, wn, exp_len, prev;
        bit  edge_seen;
        if (!rstn_i || !cfg_en_i) begin
            model_reset();
            return;
        end
        ds        = int'(cfg_data_size_i) + 1;
        wn        = int'(cfg_word_num_i) + 1;
        exp_len   = ds * wn;
        edge_seen = (int'(ws_i) != m_ws);
        prev      = m_mode;
        m_err     = 0;
        m_fs      = (edge_seen && !ws_i) ? 1 : 0;
        if (prev == 1) begin
            if (edge_seen) begin m_mode = 2; m_good = 0; end
        end else if (prev == 2 || prev == 3) begin
            if (edge_seen) begin
                if (m_half == exp_len) begin
                    if (prev == 2) begin
                        m_good++;
                        if (m_good == LOCK_FRAMES) m_mode = 3;
                    end
                end else begin
                    m_err = 1; m_good = 0; m_mode = 2;
                end
            end else if (m_half == exp_len) begin
                m_err = 1; m_mode = 1;
            end
        end else begin
            m_mode = 1;
        end
        m_k    = (prev == 0 || edge_seen) ? 0 : m_k + 1;
        m_half = edge_seen ? 1 : m_half + 1;
        m_ws   = int'(ws_i);
        m_lock = (m_mode == 3) ? 1 : 0;
        if (m_err != 0 && m_errcnt < (1 << ERR_CNT_W) - 1) m_errcnt++;
        m_bit  = m_k % ds;
        m_slot = (m_k / ds) % wn;
    endfunction

    task automatic check_outputs();
        cyc++;
        chk("ws_o",          32'(ws_o),          32'(m_ws));
        chk("bit_o",         32'(bit_o),         32'(m_bit));
        chk("slot_o",        32'(slot_o),        32'(m_slot));
        chk("frame_start_o", 32'(frame_start_o), 32'(m_fs));
        chk("lock_o",        32'(lock_o),        32'(m_lock));
        chk("err_o",         32'(err_o),         32'(m_err));
        chk("err_cnt_o",     32'(err_cnt_o),     CNT_EN ? 32'(m_errcnt) : 32'd0);
        if (frame_start_o === 1'b1) begin
            if (chk_period && last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'd64);
            last_fs = cyc;
            fs_seen++;
        end
        if (err_o === 1'b1) err_seen++;
    endtask

    // One sck cycle: drive at negedge, let posedge sample, check at next negedge.
    task automatic step(input logic ws, input logic en);
        ws_i     = ws;
        cfg_en_i = en;
        model_step();
        @(negedge sck_i);
        check_outputs();
    endtask

    task automatic half(input int n);
        ws_val = ~ws_val;
        for (int i = 0; i < n; i++) step(ws_val, 1'b1);
    endtask

    task automatic disable_then_enable(input int idle_cycles);
        ws_val = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        for (int i = 0; i < idle_cycles; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b0; ws_i = 1'b0; ws_val = 1'b0;
        cfg_data_size_i = 5'd15; cfg_word_num_i = 4'd1;
        cyc = 0; last_fs = -1; fs_seen = 0; err_seen = 0; chk_period = 1'b0;
        model_reset();
        repeat (3) @(negedge sck_i);
        check_outputs();
        rstn_i = 1'b1;

        // 1: ds=15, wn=1 -> 32-cycle halves; lock after 2 measured edges.
        disable_then_enable(2);
        fs_seen = 0; err_seen = 0; last_fs = -1; chk_period = 1'b1;
        for (int h = 0; h < 8; h++) half(32);
        chk_period = 1'b0;
        chk("t1_lock", 32'(lock_o), 32'd1);
        chk("t1_fs_count", 32'(fs_seen), 32'd4);
        chk("t1_no_err", 32'(err_seen), 32'd0);

        // 2: geometry changes aligned to WS edges; each change costs one length error.
        err_seen = 0;
        cfg_data_size_i = 5'd7; cfg_word_num_i = 4'd0;
        for (int h = 0; h < 6; h++) half(8);
        chk("t2_lock_ds7", 32'(lock_o), 32'd1);
        cfg_word_num_i = 4'd3;
        for (int h = 0; h < 6; h++) half(32);
        chk("t2_lock_wn3", 32'(lock_o), 32'd1);
        chk("t2_errs", 32'(err_seen), 32'd2);

        // 3: stretched half -> overrun, back to seeking, then relock.
        half(33);
        chk("t3_unlocked", 32'(lock_o), 32'd0);
        for (int h = 0; h < 4; h++) half(32);
        chk("t3_relock", 32'(lock_o), 32'd1);

        // 4: shortened half -> length error and relock; counter holds exactly one error.
        disable_then_enable(3);
        for (int h = 0; h < 3; h++) half(32);
        half(20);
        half(32);
        chk("t4_unlocked", 32'(lock_o), 32'd0);
        half(32);
        half(32);
        chk("t4_relock", 32'(lock_o), 32'd1);
        chk("t4_err_cnt", 32'(err_cnt_o), CNT_EN ? 32'd1 : 32'd0);

        // 5: disable mid-slot, then async reset mid-cycle.
        half(32);
        half(13);
        step(ws_val, 1'b0);
        chk("t5_en_lock", 32'(lock_o), 32'd0);
        chk("t5_en_bit", 32'(bit_o), 32'd0);
        for (int i = 0; i < 5; i++) step(ws_val, 1'b1);
        for (int h = 0; h < 4; h++) half(32);
        chk("t5_relock_en", 32'(lock_o), 32'd1);
        half(11);
        #2 rstn_i = 1'b0;
        #1;
        chk("t5_rst_ws",   32'(ws_o),   32'd0);
        chk("t5_rst_bit",  32'(bit_o),  32'd0);
        chk("t5_rst_slot", 32'(slot_o), 32'd0);
        chk("t5_rst_lock", 32'(lock_o), 32'd0);
        model_reset();
        @(negedge sck_i);
        rstn_i = 1'b1;
        ws_val = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int h = 0; h < 4; h++) half(32);
        chk("t5_relock_rst", 32'(lock_o), 32'd1);

        // 6: maximum geometry, then error counter saturation.
        cfg_data_size_i = 5'd31; cfg_word_num_i = 4'd15;
        disable_then_enable(2);
        err_seen = 0;
        for (int h = 0; h < 5; h++) half(512);
        chk("t6_lock", 32'(lock_o), 32'd1);
        chk("t6_no_err", 32'(err_seen), 32'd0);
        for (int h = 0; h < 302; h++) half(3);
        chk("t6_err_sat", 32'(err_cnt_o), CNT_EN ? 32'd255 : 32'd0);

        // Randomized geometry and half lengths, mostly correct, some short or long.
        for (int r = 0; r < 8; r++) begin
            cfg_data_size_i = 5'($urandom_range(0, 7));
            cfg_word_num_i  = 4'($urandom_range(0, 3));
            disable_then_enable(int'($urandom_range(0, 3)));
            for (int h = 0; h < 30; h++) begin
                int e;
                e = (int'(cfg_data_size_i) + 1) * (int'(cfg_word_num_i) + 1);
                if ($urandom_range(0, 3) != 0) half(e);
                else half(int'($urandom_range(1, e + 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
